// File: rtl/prog_loader.sv
// prog_loader: boot-time framed byte-stream loader that fills program memory and releases the CPU on a good checksum
module prog_loader #(
  parameter int ADDR_W = 12,
  parameter int TIMEOUT = 1024,
  parameter logic [7:0] HDR = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              boot_req,
  output logic              pm_we,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [15:0]       pm_wdata,
  output logic              cpu_hold,
  output logic              bootstrapping,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   loaded_count
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {WAIT_HDR, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, RUN, ERR} state_t;
  state_t state, state_n;
  logic [3:0] nh;
  logic [ADDR_W-1:0] n, idx;
  logic [7:0] hi, chk;
  logic [TW-1:0] tmo;
  logic wr_pend, accept, busy, tmo_hit, chk_ok;
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_HDR;
    else state <= state_n;
  end
  // next-state decode, handshake and status outputs; a byte accepted on the timeout cycle suppresses the abort
  always_comb begin
    busy = state inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK};
    in_ready = state != RUN && state != ERR;
    accept = in_valid && in_ready;
    tmo_hit = busy && !accept && (int'(tmo) + 1 >= TIMEOUT);
    chk_ok = in_data == chk;
    bootstrapping = busy;
    err = state == ERR;
    pm_we = wr_pend && !rst;
    state_n = state;
    if (tmo_hit) state_n = ERR;
    else
      case (state)
        WAIT_HDR: state_n = (accept && in_data == HDR) ? LEN_HI : WAIT_HDR;
        LEN_HI:   state_n = accept ? LEN_LO : LEN_HI;
        LEN_LO:   state_n = !accept ? LEN_LO : ({nh, in_data} == 12'd0) ? CHECK : DATA_HI;
        DATA_HI:  state_n = accept ? DATA_LO : DATA_HI;
        DATA_LO:  state_n = !accept ? DATA_LO : (idx + ADDR_W'(1) == n) ? CHECK : DATA_HI;
        CHECK:    state_n = !accept ? CHECK : chk_ok ? RUN : ERR;
        RUN:      state_n = boot_req ? WAIT_HDR : RUN;
        default:  state_n = WAIT_HDR;
      endcase
  end
  // frame datapath: length, checksum, word assembly, delayed memory write, idle counter and result flags
  always_ff @(posedge clk) begin
    if (rst) begin
      nh <= '0;
      n <= '0;
      idx <= '0;
      hi <= '0;
      chk <= '0;
      tmo <= '0;
      wr_pend <= 1'b0;
      pm_addr <= '0;
      pm_wdata <= '0;
      cpu_hold <= 1'b1;
      done <= 1'b0;
      err_code <= 2'b00;
      loaded_count <= '0;
    end else begin
      wr_pend <= accept && state == DATA_LO;
      done <= accept && state == CHECK && chk_ok;
      tmo <= (busy && !accept) ? tmo + TW'(1) : '0;
      if (accept && state == WAIT_HDR && in_data == HDR) begin
        idx <= '0;
        chk <= '0;
      end
      if (accept && state == LEN_HI) nh <= in_data[3:0];
      if (accept && state == LEN_LO) n <= ADDR_W'({nh, in_data});
      if (accept && state == DATA_HI) begin
        hi <= in_data;
        chk <= chk + in_data;
      end
      if (accept && state == DATA_LO) begin
        chk <= chk + in_data;
        pm_addr <= idx;
        pm_wdata <= {hi, in_data};
        idx <= idx + ADDR_W'(1);
      end
      if (accept && state == CHECK && chk_ok) begin
        loaded_count <= {1'b0, n};
        cpu_hold <= 1'b0;
      end
      if (state == RUN && boot_req) cpu_hold <= 1'b1;
      if (tmo_hit) err_code <= 2'b10;
      else if (accept && state == CHECK && !chk_ok) err_code <= 2'b01;
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: frame-level reference model plus directed frames for prog_loader
module tb_prog_loader;
  localparam int ADDR_W = 12;
  localparam int TIMEOUT = 1024;
  localparam logic [7:0] HDR = 8'hA5;
  logic clk = 0, rst = 1, in_valid = 0, boot_req = 0;
  logic [7:0] in_data = 0;
  logic in_ready, pm_we, cpu_hold, bootstrapping, done, err;
  logic [ADDR_W-1:0] pm_addr;
  logic [15:0] pm_wdata;
  logic [1:0] err_code;
  logic [ADDR_W:0] loaded_count;
  int n_chk = 0, n_err = 0, wcnt = 0;
  logic [15:0] dut_mem [4096];
  logic [15:0] m_mem [4096];
  int pos = -1, nw = 0, sum = 0, hi = 0, idle = 0;
  int e_addr = 0, e_wdata = 0, e_code = 0, e_cnt = 0;
  bit m_run = 0, m_err = 0, hold = 1, e_we = 0, e_done = 0, live = 0;

  prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .HDR(HDR)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .boot_req(boot_req), .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata),
    .cpu_hold(cpu_hold), .bootstrapping(bootstrapping), .done(done), .err(err),
    .err_code(err_code), .loaded_count(loaded_count));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // frame model: tracks position within the frame by byte count rather than by named phases
  always @(posedge clk) begin
    bit acc;
    if (e_we && !rst) m_mem[e_addr] = e_wdata[15:0];
    if (rst) begin
      pos = -1; m_run = 0; m_err = 0; hold = 1; e_we = 0; e_addr = 0; e_wdata = 0;
      e_done = 0; e_code = 0; e_cnt = 0; idle = 0; live = 1;
    end else begin
      acc = in_valid && !m_run && !m_err;
      e_we = 0;
      e_done = 0;
      if (m_err) m_err = 0;
      else if (m_run) begin
        if (boot_req) begin m_run = 0; hold = 1; end
      end else if (pos < 0) begin
        if (acc && in_data == HDR) begin pos = 0; sum = 0; idle = 0; end
      end else if (!acc) begin
        idle++;
        if (idle == TIMEOUT) begin m_err = 1; e_code = 2; pos = -1; end
      end else begin
        idle = 0;
        if (pos == 0) nw = (int'(in_data) % 16) * 256;
        else if (pos == 1) nw += int'(in_data);
        else if (pos < 2 + 2 * nw) begin
          sum = (sum + int'(in_data)) % 256;
          if (pos % 2 == 0) hi = int'(in_data);
          else begin e_we = 1; e_addr = (pos - 2) / 2; e_wdata = hi * 256 + int'(in_data); end
        end else if (int'(in_data) == sum) begin m_run = 1; hold = 0; e_done = 1; e_cnt = nw; end
        else begin m_err = 1; e_code = 1; end
        pos = (m_run || m_err) ? -1 : pos + 1;
      end
    end
  end

  // per-cycle comparison of every output against the model, plus a record of observed writes
  always @(negedge clk) begin
    if (live) begin
      if (pm_we === 1'b1) begin dut_mem[pm_addr] = pm_wdata; wcnt++; end
      chk("in_ready", int'(in_ready), int'(!m_run && !m_err));
      chk("pm_we", int'(pm_we), int'(e_we && !rst));
      chk("pm_addr", int'(pm_addr), e_addr);
      chk("pm_wdata", int'(pm_wdata), e_wdata);
      chk("cpu_hold", int'(cpu_hold), int'(hold));
      chk("bootstrapping", int'(bootstrapping), int'(pos >= 0));
      chk("done", int'(done), int'(e_done));
      chk("err", int'(err), int'(m_err));
      chk("err_code", int'(err_code), e_code);
      chk("loaded_count", int'(loaded_count), e_cnt);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1; in_data = b;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic send_all(input logic [7:0] bs [$]);
    foreach (bs[i]) send(bs[i]);
  endtask

  task automatic boot;
    boot_req = 1; tick(1); boot_req = 0;
  endtask

  initial begin
    int w0;
    for (int i = 0; i < 4096; i++) begin dut_mem[i] = 0; m_mem[i] = 0; end
    tick(2);
    rst = 0;
    chk("reset cpu_hold", int'(cpu_hold), 1);
    chk("reset loaded_count", int'(loaded_count), 0);
    chk("reset err_code", int'(err_code), 0);
    send_all('{8'hA5, 8'h00, 8'h02, 8'h10, 8'h23, 8'h60, 8'h05, 8'h98});
    chk("good done", int'(done), 1);
    chk("good cpu_hold", int'(cpu_hold), 0);
    chk("good loaded_count", int'(loaded_count), 2);
    tick(2);
    chk("good writes", wcnt, 2);
    chk("good mem0", int'(dut_mem[0]), 16'h1023);
    chk("good mem1", int'(dut_mem[1]), 16'h6005);
    chk("model mem0", int'(m_mem[0]), 16'h1023);
    in_valid = 1; in_data = HDR;
    tick(3);
    chk("run in_ready", int'(in_ready), 0);
    chk("run cpu_hold", int'(cpu_hold), 0);
    in_valid = 0;
    boot;
    chk("boot cpu_hold", int'(cpu_hold), 1);
    send_all('{8'hA5, 8'h00, 8'h02, 8'h10, 8'h23, 8'h60, 8'h05, 8'h99});
    chk("bad err", int'(err), 1);
    chk("bad err_code", int'(err_code), 1);
    chk("bad cpu_hold", int'(cpu_hold), 1);
    tick(1);
    w0 = wcnt;
    send_all('{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00});
    chk("empty done", int'(done), 1);
    chk("empty loaded_count", int'(loaded_count), 0);
    tick(1);
    chk("empty no writes", wcnt - w0, 0);
    boot;
    send_all('{8'hA5, 8'h00});
    tick(TIMEOUT - 1);
    chk("pre-timeout err", int'(err), 0);
    tick(1);
    chk("timeout err", int'(err), 1);
    chk("timeout err_code", int'(err_code), 2);
    tick(1);
    send_all('{8'hA5, 8'h00});
    tick(TIMEOUT - 1);
    send(8'h01);
    chk("late byte err", int'(err), 0);
    chk("late byte bootstrapping", int'(bootstrapping), 1);
    send_all('{8'h12, 8'h34, 8'h46});
    chk("reload done", int'(done), 1);
    chk("reload loaded_count", int'(loaded_count), 1);
    tick(1);
    chk("reload mem0", int'(dut_mem[0]), 16'h1234);
    chk("reload mem1 kept", int'(dut_mem[1]), 16'h6005);
    chk("model reload mem0", int'(m_mem[0]), 16'h1234);
    boot;
    send_all('{8'hA5, 8'h00, 8'h02, 8'hAB, 8'hCD});
    w0 = wcnt;
    rst = 1;
    #1;
    chk("rst pm_we", int'(pm_we), 0);
    tick(1);
    chk("rst no write", wcnt - w0, 0);
    chk("rst cpu_hold", int'(cpu_hold), 1);
    chk("rst bootstrapping", int'(bootstrapping), 0);
    chk("rst pm_addr", int'(pm_addr), 0);
    chk("rst pm_wdata", int'(pm_wdata), 0);
    chk("rst mem0 kept", int'(dut_mem[0]), 16'h1234);
    rst = 0;
    tick(3);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
